// File: rtl/reg_datos_ctrl.sv
// reg_datos_ctrl: arbitrates the two Reg_datos byte-write paths, counts bytes
// and presents a complete word until the consumer acknowledges it.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clear           synchronous abort of the partial/complete word
//   req_int/ext     byte-write requests (internal -> WR1D, external -> WR2D)
//   gnt_int/ext     one-cycle grant pulses
//   wr1d/wr2d       Reg_datos write strobes (copies of the grants)
//   byte_cnt        bytes granted in the current word
//   word_valid      complete word held in Reg_datos
//   word_ack        consumer has taken the word
//   busy            controller is not idle
module reg_datos_ctrl #(
    parameter int unsigned BYTES_PER_WORD = 4,
    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             req_int,
    input  logic             req_ext,
    output logic             gnt_int,
    output logic             gnt_ext,
    output logic             wr1d,
    output logic             wr2d,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             word_valid,
    input  logic             word_ack,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTES_PER_WORD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wv_q, wv_d;
    logic             gi_q, gi_d;
    logic             ge_q, ge_d;
    logic             busy_q, busy_d;
    // 1: external source won the last tie, so internal wins the next one
    logic             last_ext_q, last_ext_d;

    logic             elig;
    logic             ri;
    logic             re;

    // A source is blind to its own request during its grant cycle, so one
    // request produces exactly one grant.
    assign ri   = req_int & ~gi_q;
    assign re   = req_ext & ~ge_q;
    assign elig = (state_q != HOLD) && (cnt_q < FULL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wv_d       = wv_q;
        gi_d       = 1'b0;
        ge_d       = 1'b0;
        last_ext_d = last_ext_q;

        case (state_q)
            IDLE, FILL: begin
                if (elig && (ri || re)) begin
                    if (ri && re) begin
                        gi_d       = last_ext_q;
                        ge_d       = ~last_ext_q;
                        last_ext_d = ~last_ext_q;
                    end else begin
                        gi_d = ri;
                        ge_d = re;
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FILL;
                end else if (state_q == FILL && cnt_q == FULL) begin
                    // final strobe cycle has passed; word now in Reg_datos
                    state_d = HOLD;
                    wv_d    = 1'b1;
                end
            end
            HOLD: begin
                if (word_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wv_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                wv_d    = 1'b0;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            wv_d    = 1'b0;
            gi_d    = 1'b0;
            ge_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wv_q       <= 1'b0;
            gi_q       <= 1'b0;
            ge_q       <= 1'b0;
            busy_q     <= 1'b0;
            last_ext_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wv_q       <= wv_d;
            gi_q       <= gi_d;
            ge_q       <= ge_d;
            busy_q     <= busy_d;
            last_ext_q <= last_ext_d;
        end
    end

    assign gnt_int    = gi_q;
    assign gnt_ext    = ge_q;
    assign wr1d       = gi_q;
    assign wr2d       = ge_q;
    assign byte_cnt   = cnt_q;
    assign word_valid = wv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_reg_datos_ctrl.sv
// tb_reg_datos_ctrl: directed vectors for reg_datos_ctrl with hand-computed
// expected output words {gi,ge,wr1d,wr2d,word_valid,busy,byte_cnt}.
module tb_reg_datos_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       req_int;
    logic       req_ext;
    logic       gnt_int;
    logic       gnt_ext;
    logic       wr1d;
    logic       wr2d;
    logic [2:0] byte_cnt;
    logic       word_valid;
    logic       word_ack;
    logic       busy;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    reg_datos_ctrl #(.BYTES_PER_WORD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .req_int   (req_int),
        .req_ext   (req_ext),
        .gnt_int   (gnt_int),
        .gnt_ext   (gnt_ext),
        .wr1d      (wr1d),
        .wr2d      (wr2d),
        .byte_cnt  (byte_cnt),
        .word_valid(word_valid),
        .word_ack  (word_ack),
        .busy      (busy)
    );

    logic [8:0] obs;
    assign obs = {gnt_int, gnt_ext, wr1d, wr2d, word_valid, busy, byte_cnt};

    function automatic logic [8:0] ev(input logic gi, input logic ge,
                                      input logic wv, input logic bz,
                                      input int cnt);
        logic [2:0] c;
        c = 3'(cnt);
        return {gi, ge, gi, ge, wv, bz, c};
    endfunction

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        req_int  = 1'b0;
        req_ext  = 1'b0;
        word_ack = 1'b0;
        tick();
        tick();
        chk("reset", obs, ev(0, 0, 0, 0, 0));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle", obs, ev(0, 0, 0, 0, 0));
        end

        // internal source alone: grant every other cycle
        req_int = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            int c;
            c = (e + 1) / 2;
            if (c > 4) c = 4;
            tick();
            chk($sformatf("int_fill%0d", e), obs,
                ev((e % 2 == 1) && (e <= 7), 0, e >= 8, 1, c));
        end
        req_int  = 1'b0;
        word_ack = 1'b1;
        tick();
        chk("ack1", obs, ev(0, 0, 0, 0, 0));
        word_ack = 1'b0;

        // both held: INT, EXT, INT, EXT; ack ignored while filling
        req_int  = 1'b1;
        req_ext  = 1'b1;
        word_ack = 1'b1;
        tick();
        chk("alt1", obs, ev(1, 0, 0, 1, 1));
        tick();
        chk("alt2", obs, ev(0, 1, 0, 1, 2));
        word_ack = 1'b0;
        tick();
        chk("alt3", obs, ev(1, 0, 0, 1, 3));
        tick();
        chk("alt4", obs, ev(0, 1, 0, 1, 4));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold", obs, ev(0, 0, 1, 1, 4));
        end

        // ack with external still pending
        req_int  = 1'b0;
        word_ack = 1'b1;
        tick();
        chk("ack2", obs, ev(0, 0, 0, 0, 0));
        word_ack = 1'b0;
        tick();
        chk("pend_ext", obs, ev(0, 1, 0, 1, 1));

        // second byte then clear
        req_ext = 1'b0;
        req_int = 1'b1;
        tick();
        chk("cnt2", obs, ev(1, 0, 0, 1, 2));
        req_int = 1'b0;
        clear   = 1'b1;
        tick();
        chk("clear", obs, ev(0, 0, 0, 0, 0));
        clear = 1'b0;

        // last tie went to INT and clear keeps it: EXT wins this tie
        req_int = 1'b1;
        req_ext = 1'b1;
        tick();
        chk("refill1", obs, ev(0, 1, 0, 1, 1));
        tick();
        chk("refill2", obs, ev(1, 0, 0, 1, 2));
        tick();
        chk("refill3", obs, ev(0, 1, 0, 1, 3));
        tick();
        chk("refill4", obs, ev(1, 0, 0, 1, 4));
        tick();
        chk("refill_wv", obs, ev(0, 0, 1, 1, 4));
        req_int  = 1'b0;
        req_ext  = 1'b0;
        word_ack = 1'b1;
        tick();
        chk("ack3", obs, ev(0, 0, 0, 0, 0));
        word_ack = 1'b0;

        // tie to INT, then EXT pulse hit by reset plus ack
        req_int = 1'b1;
        req_ext = 1'b1;
        tick();
        chk("pre_rst1", obs, ev(1, 0, 0, 1, 1));
        tick();
        chk("pre_rst2", obs, ev(0, 1, 0, 1, 2));
        req_int  = 1'b0;
        req_ext  = 1'b0;
        rst      = 1'b1;
        word_ack = 1'b1;
        tick();
        chk("rst_mid", obs, ev(0, 0, 0, 0, 0));
        rst      = 1'b0;
        word_ack = 1'b0;
        req_int  = 1'b1;
        req_ext  = 1'b1;
        tick();
        chk("post_rst_tie", obs, ev(1, 0, 0, 1, 1));
        req_int = 1'b0;
        req_ext = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
